mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the instruction-fetch requester (I) and the

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (I) and data access (D).
// One access in flight; D has priority, bounded by a streak limit so I cannot starve.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [1:0]    state;
    logic          owner_d;
    logic          acc_we;
    logic [SW-1:0] streak;
    logic [CW-1:0] wait_cnt;
    logic          pick_d;

    // D wins any contest except when it has already taken MAX_STREAK grants in a row against I.
    always_comb begin
        pick_d = d_req && (!i_req || (streak != SW'(MAX_STREAK)));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            owner_d   <= 1'b0;
            acc_we    <= 1'b0;
            streak    <= '0;
            wait_cnt  <= '0;
            i_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        owner_d   <= pick_d;
                        acc_we    <= pick_d && d_we;
                        mem_addr  <= pick_d ? d_addr : i_addr;
                        mem_wdata <= pick_d ? d_wdata : '0;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_d && d_we;
                        d_gnt     <= pick_d;
                        i_gnt     <= !pick_d;
                        streak    <= (pick_d && i_req) ? streak + SW'(1) : '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= CW'(MEM_LAT - 1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        // Capture straight into the owner's rdata so it holds until its next response.
                        if (owner_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= acc_we ? '0 : mem_rdata;
                        end else begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand sequences for
// streak fairness, longer memory latency, mid-access reset and idle behaviour.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;

    logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we;
    logic [31:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
    logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we;
    logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_STREAK(4)) dut1 (
        .CLK(CLK), .RST(RST),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_STREAK(4)) dut3 (
        .CLK(CLK), .RST(RST),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr, dw;
        logic [31:0] da, dwd, mrd;
        logic        ig, irv;
        logic [31:0] ird;
        logic        dg, drv;
        logic [31:0] drd;
        logic        en, we;
        logic [31:0] ma, mwd;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mrd,
                                input logic ig, input logic irv, input logic [31:0] ird,
                                input logic dg, input logic drv, input logic [31:0] drd,
                                input logic en, input logic we, input logic [31:0] ma,
                                input logic [31:0] mwd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.mrd = mrd;
        v.ig = ig; v.irv = irv; v.ird = ird; v.dg = dg; v.drv = drv; v.drd = drd;
        v.en = en; v.we = we; v.ma = ma; v.mwd = mwd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_i_gnt"},     a_i_gnt, 0);
        chk({tag, "_i_rvalid"},  a_i_rvalid, 0);
        chk({tag, "_i_rdata"},   a_i_rdata, 0);
        chk({tag, "_d_gnt"},     a_d_gnt, 0);
        chk({tag, "_d_rvalid"},  a_d_rvalid, 0);
        chk({tag, "_d_rdata"},   a_d_rdata, 0);
        chk({tag, "_mem_en"},    a_mem_en, 0);
        chk({tag, "_mem_we"},    a_mem_we, 0);
        chk({tag, "_mem_addr"},  a_mem_addr, 0);
        chk({tag, "_mem_wdata"}, a_mem_wdata, 0);
    endtask

    vec_t tbl[16];
    logic exp_d[10];

    initial begin
        // Row k: inputs during cycle k, expected outputs during cycle k+1.
        tbl[0]  = mk(1, 32'h40, 0, 0, 0,     0,    0,            1, 0, 0,            0, 0, 0,            1, 0, 32'h40, 0);
        tbl[1]  = mk(0, 0,      0, 0, 0,     0,    0,            0, 0, 0,            0, 0, 0,            0, 0, 32'h40, 0);
        tbl[2]  = mk(0, 0,      0, 0, 0,     0,    32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 0, 0,            0, 0, 32'h40, 0);
        tbl[3]  = mk(0, 0,      0, 0, 0,     0,    0,            0, 0, 32'hDEADBEEF, 0, 0, 0,            0, 0, 32'h40, 0);
        tbl[4]  = mk(1, 32'h80, 1, 1, 32'h10, 32'h55, 0,         0, 0, 32'hDEADBEEF, 1, 0, 0,            1, 1, 32'h10, 32'h55);
        tbl[5]  = mk(1, 32'h80, 0, 0, 0,     0,    0,            0, 0, 32'hDEADBEEF, 0, 0, 0,            0, 0, 32'h10, 32'h55);
        tbl[6]  = mk(1, 32'h80, 0, 0, 0,     0,    32'h12345678, 0, 0, 32'hDEADBEEF, 0, 1, 0,            0, 0, 32'h10, 32'h55);
        tbl[7]  = mk(1, 32'h80, 0, 0, 0,     0,    0,            0, 0, 32'hDEADBEEF, 0, 0, 0,            0, 0, 32'h10, 32'h55);
        tbl[8]  = mk(1, 32'h80, 0, 0, 0,     0,    0,            1, 0, 32'hDEADBEEF, 0, 0, 0,            1, 0, 32'h80, 0);
        tbl[9]  = mk(0, 0,      0, 0, 0,     0,    0,            0, 0, 32'hDEADBEEF, 0, 0, 0,            0, 0, 32'h80, 0);
        tbl[10] = mk(0, 0,      0, 0, 0,     0,    32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 0, 0, 0,            0, 0, 32'h80, 0);
        tbl[11] = mk(0, 0,      0, 0, 0,     0,    0,            0, 0, 32'hCAFEF00D, 0, 0, 0,            0, 0, 32'h80, 0);
        tbl[12] = mk(0, 0,      1, 0, 32'h20, 0,   0,            0, 0, 32'hCAFEF00D, 1, 0, 0,            1, 0, 32'h20, 0);
        tbl[13] = mk(0, 0,      0, 0, 0,     0,    0,            0, 0, 32'hCAFEF00D, 0, 0, 0,            0, 0, 32'h20, 0);
        tbl[14] = mk(0, 0,      0, 0, 0,     0,    32'hA5A5A5A5, 0, 0, 32'hCAFEF00D, 0, 1, 32'hA5A5A5A5, 0, 0, 32'h20, 0);
        tbl[15] = mk(0, 0,      0, 0, 0,     0,    0,            0, 0, 32'hCAFEF00D, 0, 0, 32'hA5A5A5A5, 0, 0, 32'h20, 0);
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        do_reset();
        chk_all_zero("rst");
        chk("rst_b_mem_en", b_mem_en, 0);
        chk("rst_b_d_gnt", b_d_gnt, 0);

        // Single I read, D write vs I contention, D read
        for (int k = 0; k < 16; k++) begin
            i_req = tbl[k].ir; i_addr = tbl[k].ia; d_req = tbl[k].dr; d_we = tbl[k].dw;
            d_addr = tbl[k].da; d_wdata = tbl[k].dwd; mem_rdata = tbl[k].mrd;
            step();
            chk($sformatf("r%0d_i_gnt", k),     a_i_gnt,     tbl[k].ig);
            chk($sformatf("r%0d_i_rvalid", k),  a_i_rvalid,  tbl[k].irv);
            chk($sformatf("r%0d_i_rdata", k),   a_i_rdata,   tbl[k].ird);
            chk($sformatf("r%0d_d_gnt", k),     a_d_gnt,     tbl[k].dg);
            chk($sformatf("r%0d_d_rvalid", k),  a_d_rvalid,  tbl[k].drv);
            chk($sformatf("r%0d_d_rdata", k),   a_d_rdata,   tbl[k].drd);
            chk($sformatf("r%0d_mem_en", k),    a_mem_en,    tbl[k].en);
            chk($sformatf("r%0d_mem_we", k),    a_mem_we,    tbl[k].we);
            chk($sformatf("r%0d_mem_addr", k),  a_mem_addr,  tbl[k].ma);
            chk($sformatf("r%0d_mem_wdata", k), a_mem_wdata, tbl[k].mwd);
        end

        // 20 idle cycles: nothing issued or returned
        idle_inputs();
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("idle%0d_activity", c),
                {a_mem_en, a_i_gnt, a_d_gnt, a_i_rvalid, a_d_rvalid}, 0);
        end

        // Streak fairness, continuing from idle (streak must still be 0)
        begin
            int ng;
            ng = 0;
            i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
            for (int c = 0; c < 200 && ng < 10; c++) begin
                step();
                chk($sformatf("excl_gnt_c%0d", c), a_i_gnt & a_d_gnt, 0);
                chk($sformatf("excl_rv_c%0d", c), a_i_rvalid & a_d_rvalid, 0);
                if (a_i_gnt || a_d_gnt) begin
                    chk($sformatf("order%0d_is_d", ng), a_d_gnt, exp_d[ng]);
                    ng++;
                end
            end
            chk("order_count", ng, 10);
        end

        // MEM_LAT=3 D read
        do_reset();
        for (int k = 0; k < 7; k++) begin
            d_req = (k == 0); d_we = 1'b0; d_addr = 32'h30;
            mem_rdata = (k == 4) ? 32'h0BADC0DE : 32'h11111111;
            step();
            chk($sformatf("lat3_t%0d_d_gnt", k + 1), b_d_gnt, (k + 1 == 1));
            chk($sformatf("lat3_t%0d_mem_en", k + 1), b_mem_en, (k + 1 == 1));
            chk($sformatf("lat3_t%0d_d_rvalid", k + 1), b_d_rvalid, (k + 1 == 5));
            if (k + 1 == 5) chk("lat3_d_rdata", b_d_rdata, 32'h0BADC0DE);
        end

        // Reset during WAIT of an I read
        do_reset();
        i_req = 1'b1; i_addr = 32'h44;
        step();
        chk("rw_i_gnt", a_i_gnt, 1);
        chk("rw_mem_addr", a_mem_addr, 32'h44);
        i_req = 1'b0;
        step();
        RST = 1'b1; mem_rdata = 32'h99999999;
        step();
        chk_all_zero("rw_after");
        RST = 1'b0; mem_rdata = '0;
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 6; c++) begin
                step();
                seen = seen | a_i_rvalid;
            end
            chk("rw_no_i_rvalid", seen, 0);
        end
        i_req = 1'b1; i_addr = 32'h48;
        step();
        chk("rw2_i_gnt", a_i_gnt, 1);
        chk("rw2_mem_addr", a_mem_addr, 32'h48);
        i_req = 1'b0;
        step();
        mem_rdata = 32'h77;
        step();
        chk("rw2_i_rvalid", a_i_rvalid, 1);
        chk("rw2_i_rdata", a_i_rdata, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
